// File: rtl/tilt_position_tracker.sv
// -----------------------------------------------------------------------------
// tilt_position_tracker
//
// Integrates filtered signed X/Y acceleration samples into a bounded 2-D
// screen position, for example a cursor or a ball. Each accepted sample is
// processed in three steps:
//   1. A dead-zone suppresses small tilts.
//   2. The remaining magnitude is scaled down by a right shift and capped.
//   3. The result is added to the position registers, clamped to the screen
//      edges.
//
// Ports
//   iCLK        system clock
//   iRST        synchronous active-high reset
//   iDATA_X     signed X acceleration sample
//   iDATA_Y     signed Y acceleration sample
//   iVALID      one-cycle strobe: new X/Y sample present
//   iCENTER     one-cycle request to move the position back to screen centre
//   oPOS_X      current X position (0..MAX_X)
//   oPOS_Y      current Y position (0..MAX_Y)
//   oPOS_VALID  one-cycle pulse: position registers were just written
//   oBUSY       high while a sample is being processed
//   oAT_EDGE    high when either coordinate sits at 0 or at its maximum
//   oDROP_CNT   saturating count of samples that arrived while busy
//
// FSM states
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for iVALID; the sample is captured on acceptance
//   ST_SCALE | dead-zone / shift / cap applied; steps registered
//   ST_ACCUM | steps added to the positions with clamping; oPOS_VALID pulses
// -----------------------------------------------------------------------------
module tilt_position_tracker #(
    parameter int DATA_W   = 16,
    parameter int POS_W    = 10,
    parameter int DEADZONE = 50,
    parameter int SHIFT    = 4,
    parameter int MAX_STEP = 16,
    parameter int MAX_X    = 639,
    parameter int MAX_Y    = 479,
    parameter int INV_Y    = 1
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic signed [DATA_W-1:0] iDATA_X,
    input  logic signed [DATA_W-1:0] iDATA_Y,
    input  logic                     iVALID,
    input  logic                     iCENTER,
    output logic        [POS_W-1:0]  oPOS_X,
    output logic        [POS_W-1:0]  oPOS_Y,
    output logic                     oPOS_VALID,
    output logic                     oBUSY,
    output logic                     oAT_EDGE,
    output logic        [7:0]        oDROP_CNT
);

    // Steps and sums share one signed width. Two bits of headroom above
    // POS_W are enough: one bit for the carry of pos + step, and one bit
    // for the sign.
    localparam int STEP_W = POS_W + 2;

    localparam logic        [DATA_W:0]   DZ_M    = (DATA_W+1)'(DEADZONE);
    localparam logic        [DATA_W:0]   CAP_M   = (DATA_W+1)'(MAX_STEP);
    localparam logic        [STEP_W-1:0] CAP_S   = STEP_W'(MAX_STEP);
    localparam logic        [POS_W-1:0]  CTR_X   = POS_W'((MAX_X + 1) / 2);
    localparam logic        [POS_W-1:0]  CTR_Y   = POS_W'((MAX_Y + 1) / 2);
    localparam logic        [POS_W-1:0]  MAX_X_P = POS_W'(MAX_X);
    localparam logic        [POS_W-1:0]  MAX_Y_P = POS_W'(MAX_Y);
    localparam logic signed [STEP_W-1:0] MAX_X_S = STEP_W'(MAX_X);
    localparam logic signed [STEP_W-1:0] MAX_Y_S = STEP_W'(MAX_Y);
    localparam logic                     INV_Y_B = (INV_Y != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCALE = 2'd1,
        ST_ACCUM = 2'd2
    } state_t;

    state_t                     state_q,     state_d;
    logic signed [DATA_W-1:0]   data_x_q,    data_x_d;
    logic signed [DATA_W-1:0]   data_y_q,    data_y_d;
    logic signed [STEP_W-1:0]   step_x_q,    step_x_d;
    logic signed [STEP_W-1:0]   step_y_q,    step_y_d;
    logic        [POS_W-1:0]    pos_x_q,     pos_x_d;
    logic        [POS_W-1:0]    pos_y_q,     pos_y_d;
    logic                       pos_valid_q, pos_valid_d;
    logic                       at_edge_q,   at_edge_d;
    logic        [7:0]          drop_cnt_q,  drop_cnt_d;

    // Converts one raw acceleration word into a signed step.
    // The magnitude is taken one bit wider than the input, so the most
    // negative input value folds correctly instead of wrapping.
    function automatic logic signed [STEP_W-1:0] calc_step(
        input logic signed [DATA_W-1:0] d,
        input logic                     invert
    );
        logic [DATA_W:0]   ext;
        logic [DATA_W:0]   mag;
        logic [DATA_W:0]   scaled;
        logic [STEP_W-1:0] lim;
        ext = {d[DATA_W-1], d};
        mag = d[DATA_W-1] ? -ext : ext;
        if (mag < DZ_M) begin
            lim = '0;
        end else begin
            scaled = (mag - DZ_M) >> SHIFT;
            lim    = (scaled > CAP_M) ? CAP_S : STEP_W'(scaled);
        end
        calc_step = (d[DATA_W-1] ^ invert) ? -$signed(lim) : $signed(lim);
    endfunction

    // Adds a step to a position and clamps the result to the range 0..max_s.
    function automatic logic [POS_W-1:0] clamp_add(
        input logic        [POS_W-1:0]  pos,
        input logic signed [STEP_W-1:0] step,
        input logic signed [STEP_W-1:0] max_s
    );
        logic signed [STEP_W-1:0] sum;
        sum = $signed({2'b00, pos}) + step;
        if (sum[STEP_W-1]) begin
            clamp_add = '0;
        end else if (sum > max_s) begin
            clamp_add = POS_W'(max_s);
        end else begin
            clamp_add = sum[POS_W-1:0];
        end
    endfunction

    always_comb begin
        state_d     = state_q;
        data_x_d    = data_x_q;
        data_y_d    = data_y_q;
        step_x_d    = step_x_q;
        step_y_d    = step_y_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        pos_valid_d = 1'b0;
        drop_cnt_d  = drop_cnt_q;

        if (iCENTER) begin
            // Centre overrides everything. A sample that is in flight, or
            // one that arrives in the same cycle, is discarded without
            // being counted as dropped.
            state_d     = ST_IDLE;
            pos_x_d     = CTR_X;
            pos_y_d     = CTR_Y;
            pos_valid_d = 1'b1;
        end else begin
            if (iVALID && (state_q != ST_IDLE) && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (iVALID) begin
                        data_x_d = iDATA_X;
                        data_y_d = iDATA_Y;
                        state_d  = ST_SCALE;
                    end
                end
                ST_SCALE: begin
                    step_x_d = calc_step(data_x_q, 1'b0);
                    step_y_d = calc_step(data_y_q, INV_Y_B);
                    state_d  = ST_ACCUM;
                end
                ST_ACCUM: begin
                    pos_x_d     = clamp_add(pos_x_q, step_x_q, MAX_X_S);
                    pos_y_d     = clamp_add(pos_y_q, step_y_q, MAX_Y_S);
                    pos_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Derived from the next positions, so that oAT_EDGE lines up with
        // the cycle in which the positions change.
        at_edge_d = (pos_x_d == '0) || (pos_x_d == MAX_X_P) ||
                    (pos_y_d == '0) || (pos_y_d == MAX_Y_P);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= ST_IDLE;
            data_x_q    <= '0;
            data_y_q    <= '0;
            step_x_q    <= '0;
            step_y_q    <= '0;
            pos_x_q     <= CTR_X;
            pos_y_q     <= CTR_Y;
            pos_valid_q <= 1'b0;
            at_edge_q   <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            data_x_q    <= data_x_d;
            data_y_q    <= data_y_d;
            step_x_q    <= step_x_d;
            step_y_q    <= step_y_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            pos_valid_q <= pos_valid_d;
            at_edge_q   <= at_edge_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign oPOS_X     = pos_x_q;
    assign oPOS_Y     = pos_y_q;
    assign oPOS_VALID = pos_valid_q;
    assign oBUSY      = (state_q != ST_IDLE);
    assign oAT_EDGE   = at_edge_q;
    assign oDROP_CNT  = drop_cnt_q;

endmodule

// File: tb/tb_tilt_position_tracker.sv
// -----------------------------------------------------------------------------
// Bench for tilt_position_tracker.
// The reference model works at the level of whole samples: integer step
// arithmetic per sample, clamped integer positions, and a saturating drop
// count.
// -----------------------------------------------------------------------------
module tb_tilt_position_tracker;

    localparam int DZ     = 50;
    localparam int DIV    = 16;
    localparam int CAP    = 16;
    localparam int MX     = 639;
    localparam int MY     = 479;
    localparam int CX     = 320;
    localparam int CY     = 240;

    logic               iCLK;
    logic               iRST;
    logic signed [15:0] iDATA_X;
    logic signed [15:0] iDATA_Y;
    logic               iVALID;
    logic               iCENTER;
    logic        [9:0]  oPOS_X;
    logic        [9:0]  oPOS_Y;
    logic               oPOS_VALID;
    logic               oBUSY;
    logic               oAT_EDGE;
    logic        [7:0]  oDROP_CNT;

    tilt_position_tracker dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iDATA_X    (iDATA_X),
        .iDATA_Y    (iDATA_Y),
        .iVALID     (iVALID),
        .iCENTER    (iCENTER),
        .oPOS_X     (oPOS_X),
        .oPOS_Y     (oPOS_Y),
        .oPOS_VALID (oPOS_VALID),
        .oBUSY      (oBUSY),
        .oAT_EDGE   (oAT_EDGE),
        .oDROP_CNT  (oDROP_CNT)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int total = 0;
    int bad   = 0;
    int m_x   = CX;
    int m_y   = CY;
    int m_drop = 0;

    typedef struct {
        int x;
        int y;
        int ex;
        int ey;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_step(input int d, input bit inv);
        int mag;
        int s;
        mag = (d < 0) ? -d : d;
        if (mag < DZ) begin
            s = 0;
        end else begin
            s = (mag - DZ) / DIV;
            if (s > CAP) s = CAP;
        end
        if ((d < 0) != inv) s = -s;
        return s;
    endfunction

    function automatic int ref_clamp(input int p, input int s, input int mx);
        int r;
        r = p + s;
        if (r < 0) r = 0;
        if (r > mx) r = mx;
        return r;
    endfunction

    function automatic int ref_edge();
        return ((m_x == 0) || (m_x == MX) || (m_y == 0) || (m_y == MY)) ? 1 : 0;
    endfunction

    task automatic check_model(input string tag);
        check({tag, "_pos_x"},   int'(oPOS_X),     m_x);
        check({tag, "_pos_y"},   int'(oPOS_Y),     m_y);
        check({tag, "_at_edge"}, int'(oAT_EDGE),   ref_edge());
        check({tag, "_drop"},    int'(oDROP_CNT),  m_drop);
    endtask

    // Called and returns at a falling edge. extra1/extra2 send additional
    // strobes, carrying junk data, during the two busy cycles.
    task automatic apply_sample(input int x, input int y, input bit extra1, input bit extra2);
        iDATA_X = 16'(x);
        iDATA_Y = 16'(y);
        iVALID  = 1'b1;
        @(negedge iCLK);
        check("busy_scale", int'(oBUSY), 1);
        check("valid_scale", int'(oPOS_VALID), 0);
        iVALID  = extra1;
        iDATA_X = 16'($urandom);
        iDATA_Y = 16'($urandom);
        @(negedge iCLK);
        check("busy_accum", int'(oBUSY), 1);
        iVALID  = extra2;
        iDATA_X = 16'($urandom);
        iDATA_Y = 16'($urandom);
        @(negedge iCLK);
        iVALID  = 1'b0;
        m_x    = ref_clamp(m_x, ref_step(x, 1'b0), MX);
        m_y    = ref_clamp(m_y, ref_step(y, 1'b1), MY);
        m_drop = m_drop + int'(extra1) + int'(extra2);
        if (m_drop > 255) m_drop = 255;
        check("valid_pulse", int'(oPOS_VALID), 1);
        check("busy_done", int'(oBUSY), 0);
        check_model("sample");
    endtask

    task automatic do_center();
        iCENTER = 1'b1;
        @(negedge iCLK);
        iCENTER = 1'b0;
        m_x = CX;
        m_y = CY;
        check("center_valid", int'(oPOS_VALID), 1);
        check("center_busy", int'(oBUSY), 0);
        check_model("center");
    endtask

    function automatic int rand_accel();
        logic [15:0] r;
        int sel;
        sel = int'($urandom_range(3));
        if (sel == 0) begin
            r = 16'($urandom);
            return int'($signed(r));
        end
        return int'($urandom_range(700)) - 350;
    endfunction

    initial begin
        tbl[0] = '{x:    200, y:  -40, ex: 329, ey: 240};
        tbl[1] = '{x:  32767, y: 1000, ex: 345, ey: 224};
        tbl[2] = '{x: -32768, y:    0, ex: 329, ey: 224};
        tbl[3] = '{x:   -100, y:   65, ex: 326, ey: 224};
        tbl[4] = '{x:     49, y:  -49, ex: 326, ey: 224};
        tbl[5] = '{x:     50, y:  -50, ex: 326, ey: 224};
        tbl[6] = '{x:     66, y:  -66, ex: 327, ey: 225};
        tbl[7] = '{x:   -306, y:  306, ex: 311, ey: 209};
        tbl[8] = '{x:   -322, y: -321, ex: 295, ey: 225};

        iRST    = 1'b1;
        iVALID  = 1'b0;
        iCENTER = 1'b0;
        iDATA_X = '0;
        iDATA_Y = '0;
        @(negedge iCLK);
        @(negedge iCLK);
        @(negedge iCLK);
        iRST = 1'b0;
        check("rst_pos_x", int'(oPOS_X), CX);
        check("rst_pos_y", int'(oPOS_Y), CY);
        check("rst_valid", int'(oPOS_VALID), 0);
        check("rst_busy", int'(oBUSY), 0);
        check("rst_edge", int'(oAT_EDGE), 0);
        check("rst_drop", int'(oDROP_CNT), 0);

        for (int i = 0; i < 9; i++) begin
            apply_sample(tbl[i].x, tbl[i].y, 1'b0, 1'b0);
            check("tbl_pos_x", int'(oPOS_X), tbl[i].ex);
            check("tbl_pos_y", int'(oPOS_Y), tbl[i].ey);
        end

        // Reset asserted while the sample is in SCALE: the sample is lost.
        iDATA_X = 16'sd32767;
        iDATA_Y = 16'sd32767;
        iVALID  = 1'b1;
        @(negedge iCLK);
        iVALID = 1'b0;
        iRST   = 1'b1;
        @(negedge iCLK);
        iRST   = 1'b0;
        m_x = CX;
        m_y = CY;
        m_drop = 0;
        check("midrst_busy", int'(oBUSY), 0);
        check_model("midrst");
        for (int i = 0; i < 3; i++) begin
            @(negedge iCLK);
            check("midrst_no_valid", int'(oPOS_VALID), 0);
        end
        check("midrst_hold_x", int'(oPOS_X), CX);

        // Right-edge saturation.
        for (int i = 0; i < 20; i++) apply_sample(32767, 0, 1'b0, 1'b0);
        check("sat_right_x", int'(oPOS_X), 639);
        check("sat_right_edge", int'(oAT_EDGE), 1);

        do_center();

        // Most-negative input and left-edge saturation.
        apply_sample(-32768, 0, 1'b0, 1'b0);
        check("neg_extreme_x", int'(oPOS_X), 304);
        for (int i = 0; i < 20; i++) apply_sample(-32768, 0, 1'b0, 1'b0);
        check("sat_left_x", int'(oPOS_X), 0);
        check("sat_left_edge", int'(oAT_EDGE), 1);

        do_center();

        // Three back-to-back strobes: the first is applied, two are dropped.
        apply_sample(200, 0, 1'b1, 1'b1);
        check("busy_rej_x", int'(oPOS_X), 329);
        check("busy_rej_drop", int'(oDROP_CNT), 2);

        // Move to (400,100), then send centre and a sample in the same cycle.
        do_center();
        for (int i = 0; i < 5; i++) apply_sample(32767, 0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) apply_sample(0, 1000, 1'b0, 1'b0);
        apply_sample(0, 242, 1'b0, 1'b0);
        check("prio_pre_x", int'(oPOS_X), 400);
        check("prio_pre_y", int'(oPOS_Y), 100);
        iCENTER = 1'b1;
        iVALID  = 1'b1;
        iDATA_X = 16'sd500;
        iDATA_Y = 16'sd0;
        @(negedge iCLK);
        iCENTER = 1'b0;
        iVALID  = 1'b0;
        m_x = CX;
        m_y = CY;
        check("prio_valid", int'(oPOS_VALID), 1);
        check("prio_busy", int'(oBUSY), 0);
        check_model("prio");
        @(negedge iCLK);
        check("prio_single_pulse", int'(oPOS_VALID), 0);
        check("prio_discard_x", int'(oPOS_X), CX);
        check("prio_drop", int'(oDROP_CNT), 2);

        // Random transactions checked against the model.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(7) == 0) begin
                do_center();
            end else begin
                apply_sample(rand_accel(), rand_accel(),
                             1'($urandom_range(1)), 1'($urandom_range(1)));
            end
        end

        // Continuous strobes for 450 cycles: 150 samples are accepted and
        // 300 are dropped. Zero data leaves the position unchanged.
        iDATA_X = '0;
        iDATA_Y = '0;
        iVALID  = 1'b1;
        repeat (450) @(negedge iCLK);
        iVALID = 1'b0;
        repeat (2) @(negedge iCLK);
        m_drop = m_drop + 300;
        if (m_drop > 255) m_drop = 255;
        check("drop_saturate", int'(oDROP_CNT), 255);
        check_model("drop_hold");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tilt_position_tracker.md
Name: tilt_position_tracker

Overview:
Consumes the filtered signed X/Y acceleration words from the SPI sensor controller and integrates them into a bounded 2-D screen position, such as a cursor or ball for the VGA game stage. Each accepted sample goes through a dead-zone, a shift-based scale and a step limit. It is then accumulated into the position registers with edge clamping. Sits directly downstream of the accelerometer controller and upstream of the display/game logic.

Parameters:
DATA_W, 16, width of incoming signed acceleration words
POS_W, 10, width of unsigned position outputs
DEADZONE, 50, magnitudes below this produce zero step (matches controller stop threshold)
SHIFT, 4, right-shift applied to (magnitude - DEADZONE)
MAX_STEP, 16, step magnitude cap per sample
MAX_X, 639, largest X position
MAX_Y, 479, largest Y position
INV_Y, 1, 1: positive Y acceleration decreases position Y

Ports:
iCLK  in  1  system clock
iRST  in  1  synchronous active-high reset
iDATA_X  in  DATA_W  signed X acceleration from controller
iDATA_Y  in  DATA_W  signed Y acceleration from controller
iVALID  in  1  one-cycle strobe, new X/Y sample present
iCENTER  in  1  one-cycle request to re-centre position
oPOS_X  out  POS_W  current X position
oPOS_Y  out  POS_W  current Y position
oPOS_VALID  out  1  one-cycle pulse, position updated
oBUSY  out  1  high while not IDLE
oAT_EDGE  out  1  registered, high when any position is at 0 or its MAX
oDROP_CNT  out  8  saturating count of samples rejected while busy

Behaviour:
- One clock domain (iCLK). Reset is synchronous and active-high on iRST.
- Reset values, including when iRST is asserted mid-operation:
  - oPOS_X = (MAX_X+1)/2 = 320; oPOS_Y = (MAX_Y+1)/2 = 240.
  - oPOS_VALID = 0; oBUSY = 0; oAT_EDGE = 0; oDROP_CNT = 0.
  - State returns to IDLE and any in-flight sample is discarded.
- FSM states:
  - IDLE: on iVALID, register iDATA_X/iDATA_Y and go to SCALE.
  - SCALE: compute step_x and step_y into registers, go to ACCUM.
  - ACCUM: update positions, pulse oPOS_VALID, go to IDLE.
- Latency: iVALID sampled at edge n → oPOS_X/oPOS_Y change and oPOS_VALID = 1 after edge n+2, for exactly one cycle. Maximum acceptance rate is 1 sample per 3 cycles.
- oBUSY = 1 in SCALE and ACCUM.
- iVALID while oBUSY: the sample is ignored and oDROP_CNT increments, saturating at 255. Registered data is not disturbed.
- Step arithmetic, per axis:
  - mag = |d|, computed at DATA_W+1 bits, so -32768 gives 32768 without overflow.
  - mag < DEADZONE → step = 0.
  - Otherwise step = min((mag - DEADZONE) >> SHIFT, MAX_STEP).
  - The sign of d is restored. For Y, the sign is inverted when INV_Y = 1.
- Accumulation:
  - sum = pos + step, computed signed at POS_W+2 bits.
  - sum < 0 → 0; sum > MAX → MAX; otherwise sum.
  - oPOS_VALID pulses even when the step is 0 or the result is clamped.
- oAT_EDGE is recomputed from the new positions in the same cycle they update.
- iCENTER:
  - Accepted in any state. Next edge: positions go to centre values, state goes to IDLE, oPOS_VALID pulses for one cycle.
  - Any in-flight sample is discarded and not counted as dropped.
  - iCENTER together with iVALID in IDLE: the centre wins and the sample is discarded (not counted).
- iRST has priority over iCENTER and iVALID.

Test Plan:
- Reset check: assert iRST for 2 cycles → oPOS_X = 320, oPOS_Y = 240; oPOS_VALID, oBUSY, oAT_EDGE and oDROP_CNT all 0. Repeat iRST during SCALE → no oPOS_VALID pulse follows.
- Basic step and dead-zone: iVALID with X = +200, Y = -40 → two edges later oPOS_VALID = 1, oPOS_X = 329 (150>>4 = 9), oPOS_Y = 240 (Y inside dead-zone).
- Cap, inversion and clamp:
  - X = +32767, Y = +1000 → step_x = +16; Y step capped to 16 and inverted, so oPOS_Y = 224.
  - Repeat X = +32767 twenty times → oPOS_X saturates at 639 and oAT_EDGE = 1.
- Negative extreme: X = -32768 from centre → oPOS_X = 304. Run to 0 and verify no wrap to 1023.
- Busy rejection: iVALID on three consecutive cycles → only the first sample is applied and oDROP_CNT = 2. Drive 300 rejected strobes → oDROP_CNT holds at 255.
- Centre priority: iCENTER and iVALID (X = +500) in the same IDLE cycle from position (400, 100) → position goes to (320, 240), one oPOS_VALID pulse, oDROP_CNT unchanged.
